// File: rtl/npu_pkg.sv
// Shared definitions for the systolic control path: array opcodes and the
// tile sequencer state encoding.
package npu_pkg;

  localparam logic [2:0] OP_IDLE    = 3'd0;
  localparam logic [2:0] OP_COMPUTE = 3'd1;
  localparam logic [2:0] OP_DRAIN   = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_INTRA  = 3'd5,
    ST_FIN    = 3'd6
  } state_t;

endpackage

// File: rtl/phase_counter.sv
// Phase length counter shared by STREAM/FLUSH/DRAIN: counts 0..limit-1 while
// enabled and flags the final cycle so the owner can change phase.
module phase_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         last
);

  logic [W-1:0] cnt;

  // Comparing against limit-1 keeps the maximum limit from ever wrapping cnt.
  assign last = en && (cnt == limit - 1'b1);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/gemm_tile_sequencer.sv
// Sequences one GEMM tile on the systolic array (clear, stream, flush, drain)
// and optionally hands the O buffer to the A buffer over the intra-net.
module gemm_tile_sequencer
  import npu_pkg::*;
#(
  parameter int ARRAY_N    = 16,
  parameter int ARRAY_M    = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int K_WIDTH    = 10,
  parameter int FLUSH_CYC  = ARRAY_N + ARRAY_M - 1,
  parameter int RW         = $clog2(ARRAY_N) + 1,
  parameter int CW         = $clog2(ARRAY_M) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] cfg_a_base,
  input  logic [ADDR_WIDTH-1:0] cfg_w_base,
  input  logic [ADDR_WIDTH-1:0] cfg_o_base,
  input  logic [RW-1:0]         cfg_rows,
  input  logic [CW-1:0]         cfg_cols,
  input  logic [K_WIDTH-1:0]    cfg_k,
  input  logic                  cfg_chain,
  input  logic [ADDR_WIDTH-1:0] cfg_intra_o_base,
  input  logic [ADDR_WIDTH-1:0] cfg_intra_a_base,
  input  logic                  intra_sig_end,
  output logic                  sa_reset,
  output logic                  a_buf_on,
  output logic                  w_buf_on,
  output logic [ADDR_WIDTH-1:0] a_base_addr,
  output logic [ADDR_WIDTH-1:0] w_base_addr,
  output logic [ADDR_WIDTH-1:0] o_base_addr,
  output logic [RW-1:0]         a_num_rows,
  output logic [CW-1:0]         w_num_cols,
  output logic [2:0]            operation_signal,
  output logic                  o_ag_o_on,
  output logic                  intranet_on,
  output logic                  intra_sig_start,
  output logic [ADDR_WIDTH-1:0] intra_o_base_addr,
  output logic [ADDR_WIDTH-1:0] intra_a_base_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [2:0]            state_dbg
);

  state_t               state;
  logic [K_WIDTH-1:0]   k_q;
  logic                 chain_q;
  logic [K_WIDTH-1:0]   limit;
  logic                 phase_en;
  logic                 phase_last;
  logic                 cfg_bad;

  assign state_dbg = state;

  // Handshake: start is a one-cycle request honoured only while IDLE (busy=0);
  // intra_sig_start is a one-cycle request to the intra-net, and
  // intra_sig_end is its one-cycle completion, observed only in INTRA.
  assign cfg_bad = (cfg_k == '0) || (cfg_rows == '0) || (cfg_cols == '0) ||
                   (cfg_rows > RW'(ARRAY_N)) || (cfg_cols > CW'(ARRAY_M));

  assign phase_en = (state == ST_STREAM) || (state == ST_FLUSH) || (state == ST_DRAIN);

  always_comb begin
    limit = '0;
    case (state)
      ST_STREAM: limit = k_q;
      ST_FLUSH:  limit = K_WIDTH'(FLUSH_CYC);
      ST_DRAIN:  limit = K_WIDTH'(a_num_rows);
      default:   limit = '0;
    endcase
  end

  phase_counter #(.W(K_WIDTH)) u_phase_counter (
    .clk   (clk),
    .reset (reset),
    .clear (abort),
    .en    (phase_en),
    .limit (limit),
    .last  (phase_last)
  );

  // Outputs are computed for the state being entered, so each one is
  // registered and lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset || abort) begin
      state             <= ST_IDLE;
      sa_reset          <= 1'b0;
      a_buf_on          <= 1'b0;
      w_buf_on          <= 1'b0;
      a_base_addr       <= '0;
      w_base_addr       <= '0;
      o_base_addr       <= '0;
      a_num_rows        <= '0;
      w_num_cols        <= '0;
      operation_signal  <= OP_IDLE;
      o_ag_o_on         <= 1'b0;
      intranet_on       <= 1'b0;
      intra_sig_start   <= 1'b0;
      intra_o_base_addr <= '0;
      intra_a_base_addr <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      err               <= 1'b0;
      k_q               <= '0;
      chain_q           <= 1'b0;
    end else begin
      sa_reset         <= 1'b0;
      a_buf_on         <= 1'b0;
      w_buf_on         <= 1'b0;
      operation_signal <= OP_IDLE;
      o_ag_o_on        <= 1'b0;
      intranet_on      <= 1'b0;
      intra_sig_start  <= 1'b0;
      done             <= 1'b0;
      err              <= 1'b0;
      busy             <= 1'b1;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            a_base_addr       <= cfg_a_base;
            w_base_addr       <= cfg_w_base;
            o_base_addr       <= cfg_o_base;
            a_num_rows        <= cfg_rows;
            w_num_cols        <= cfg_cols;
            k_q               <= cfg_k;
            chain_q           <= cfg_chain;
            intra_o_base_addr <= cfg_intra_o_base;
            intra_a_base_addr <= cfg_intra_a_base;
            if (cfg_bad) begin
              err <= 1'b1;
            end else begin
              state    <= ST_CLEAR;
              sa_reset <= 1'b1;
              busy     <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          state            <= ST_STREAM;
          a_buf_on         <= 1'b1;
          w_buf_on         <= 1'b1;
          operation_signal <= OP_COMPUTE;
        end
        ST_STREAM: begin
          operation_signal <= OP_COMPUTE;
          if (phase_last) begin
            state <= ST_FLUSH;
          end else begin
            a_buf_on <= 1'b1;
            w_buf_on <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (phase_last) begin
            state            <= ST_DRAIN;
            operation_signal <= OP_DRAIN;
            o_ag_o_on        <= 1'b1;
          end else begin
            operation_signal <= OP_COMPUTE;
          end
        end
        ST_DRAIN: begin
          if (phase_last) begin
            if (chain_q) begin
              state           <= ST_INTRA;
              intranet_on     <= 1'b1;
              intra_sig_start <= 1'b1;
            end else begin
              state <= ST_FIN;
              done  <= 1'b1;
              busy  <= 1'b0;
            end
          end else begin
            operation_signal <= OP_DRAIN;
            o_ag_o_on        <= 1'b1;
          end
        end
        ST_INTRA: begin
          if (intra_sig_end) begin
            state <= ST_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            intranet_on <= 1'b1;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
